// File: rtl/twos_to_signmag25_pkg.sv
// Shared definitions for the two's-complement to sign/magnitude converter:
// default geometry and the controller state type.
package ktsnc_pkg;

   localparam int KTSNC_WIDTH = 25;
   localparam int KTSNC_CHUNK = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CONV = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/twos_to_signmag25_chunk.sv
// One chunk of the serial negation: optionally inverts the chunk and adds
// the incoming carry. When not inverting, the chunk passes through and no
// carry is produced.
module twos_chunk
   import ktsnc_pkg::*;
#(
   parameter int CHUNK = KTSNC_CHUNK
) (
   input  logic             inv_i,
   input  logic [CHUNK-1:0] d_i,
   input  logic             cin_i,
   output logic [CHUNK-1:0] sum_o,
   output logic             cout_o
);

   logic [CHUNK:0] ext;

   // Conditional invert-plus-carry with carry-out in the top bit
   always_comb begin
      ext = {1'b0, d_i};
      if (inv_i) begin
         ext = {1'b0, ~d_i} + {{CHUNK{1'b0}}, cin_i};
      end
      sum_o  = ext[CHUNK-1:0];
      cout_o = ext[CHUNK];
   end

endmodule

// File: rtl/twos_to_signmag25.sv
// Multi-cycle two's-complement to sign/magnitude converter. A word is taken
// in IDLE, negated CHUNK bits per cycle (LSB chunk first) while in CONV, and
// presented in DONE until the consumer takes it.
module twos_to_signmag25
   import ktsnc_pkg::*;
#(
   parameter int WIDTH = KTSNC_WIDTH,
   parameter int CHUNK = KTSNC_CHUNK
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] data_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             sign,
   output logic [WIDTH-1:0] mag,
   output logic             zero,
   output logic             min_neg
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(NCHUNK - 1);
   localparam logic [WIDTH-1:0] MIN_NEG_PAT = {1'b1, {(WIDTH-1){1'b0}}};

   state_t           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [WIDTH-1:0] mag_q, mag_d;
   logic             sign_q, sign_d;
   logic             carry_q, carry_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [CHUNK-1:0] data_chunk;
   logic [CHUNK-1:0] mag_chunk;
   logic             chunk_cout;

   assign data_chunk = data_q[cnt_q*CHUNK +: CHUNK];

   twos_chunk #(
      .CHUNK (CHUNK)
   ) u_chunk (
      .inv_i  (sign_q),
      .d_i    (data_chunk),
      .cin_i  (carry_q),
      .sum_o  (mag_chunk),
      .cout_o (chunk_cout)
   );

   // Next-state logic: accept in IDLE, one chunk per cycle in CONV, hold in DONE
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      mag_d   = mag_q;
      sign_d  = sign_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               data_d  = data_in;
               sign_d  = data_in[WIDTH-1];
               mag_d   = '0;
               cnt_d   = '0;
               carry_d = 1'b1;
               state_d = ST_CONV;
            end
         end
         ST_CONV: begin
            mag_d[cnt_q*CHUNK +: CHUNK] = mag_chunk;
            carry_d = chunk_cout;
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and result registers; reset discards any word in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         mag_q   <= '0;
         sign_q  <= 1'b0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         mag_q   <= mag_d;
         sign_q  <= sign_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
      end
   end

   // Captured operand needs no reset: it is only read after a fresh accept
   always_ff @(posedge clk) begin
      data_q <= data_d;
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign sign      = sign_q;
   assign mag       = mag_q;
   // Only -2^(WIDTH-1) yields a negative word whose magnitude has the top bit set
   assign zero      = out_valid && (mag_q == '0);
   assign min_neg   = out_valid && sign_q && (mag_q == MIN_NEG_PAT);

endmodule

// File: tb/tb_twos_to_signmag25.sv
// Scoreboard bench for twos_to_signmag25: directed corner words, reset
// behaviour, then a long random stream with random handshakes.
module tb_twos_to_signmag25;

   localparam int W = 25;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] data_in;
   logic         out_valid;
   logic         out_ready;
   logic         sign;
   logic [W-1:0] mag;
   logic         zero;
   logic         min_neg;

   typedef struct packed {
      logic         s;
      logic [W-1:0] m;
      logic         z;
      logic         mn;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   mon_en  = 1'b0;
   bit   stream_done = 1'b0;

   always #5 clk = ~clk;

   twos_to_signmag25 dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_in   (data_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sign      (sign),
      .mag       (mag),
      .zero      (zero),
      .min_neg   (min_neg)
   );

   // Reference: interpret as a signed integer, take its absolute value
   function automatic exp_t model(input logic [W-1:0] d);
      longint v;
      exp_t   e;
      v = longint'(d);
      if (d[W-1]) v = v - (longint'(1) << W);
      e.s  = (v < 0);
      e.z  = (v == 0);
      e.mn = (v == -(longint'(1) << (W-1)));
      if (v < 0) v = -v;
      e.m  = v[W-1:0];
      return e;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] pick_word();
      logic [W-1:0] d;
      d = W'($urandom);
      if (($urandom % 8) == 0) begin
         case ($urandom % 6)
            0: d = 25'h0000000;
            1: d = 25'h1000000;
            2: d = 25'h1FFFFFF;
            3: d = 25'h0FFFFFF;
            4: d = 25'h0000001;
            default: d = 25'h1FFFFF6;
         endcase
      end
      return d;
   endfunction

   // Monitor: pops on every output handshake, checks hold and flag gating
   initial begin
      exp_t got, held, e;
      bit   have_held;
      have_held = 1'b0;
      wait (mon_en);
      forever begin
         @(negedge clk);
         #2;
         got = {sign, mag, zero, min_neg};
         if (!out_valid) begin
            have_held = 1'b0;
            chk("flags_idle", 64'({zero, min_neg}), 64'(0));
         end else begin
            if (have_held) chk("hold_stable", 64'(got), 64'(held));
            if (out_ready) begin
               if (sb.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_out: got %h expected none", got);
               end else begin
                  e = sb.pop_front();
                  chk("result", 64'(got), 64'(e));
               end
               have_held = 1'b0;
            end else begin
               held      = got;
               have_held = 1'b1;
            end
         end
      end
   end

   // Offer one word, check latency, optional stall, and single handshake
   task automatic send(input logic [W-1:0] d, input int stall);
      int b;
      int lat;
      in_valid = 1'b1;
      data_in  = d;
      #1;
      b = 0;
      while (!in_ready && b < 50) begin
         @(negedge clk);
         #1;
         b++;
      end
      chk("accept_ready", 64'(in_ready), 64'(1));
      sb.push_back(model(d));
      if (stall > 0) out_ready = 1'b0;
      lat = 0;
      while (lat < 20) begin
         @(negedge clk);
         #1;
         lat++;
         if (out_valid) break;
         in_valid = 1'($urandom % 2);
         data_in  = W'($urandom);
      end
      in_valid = 1'b0;
      chk("latency", 64'(lat), 64'(6));
      for (int i = 0; i < stall; i++) begin
         chk("stall_in_ready", 64'(in_ready), 64'(0));
         chk("stall_out_valid", 64'(out_valid), 64'(1));
         @(negedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      #1;
      chk("post_hs_out_valid", 64'(out_valid), 64'(0));
      chk("post_hs_in_ready", 64'(in_ready), 64'(1));
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      data_in   = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'(1));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_sign", 64'(sign), 64'(0));
      chk("rst_mag", 64'(mag), 64'(0));
      chk("rst_flags", 64'({zero, min_neg}), 64'(0));
      @(negedge clk);
      rst    = 1'b0;
      mon_en = 1'b1;

      send(25'h1FFFFFF, 0);
      send(25'h1000000, 0);
      send(25'h0000000, 0);
      send(25'h0ABCDEF, 0);
      send(25'h1FFFFF6, 3);

      // Reset during the third CONV cycle drops the word
      @(negedge clk);
      #1;
      in_valid = 1'b1;
      data_in  = 25'h1ABCDEF;
      @(negedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      #1;
      rst = 1'b0;
      chk("midrst_in_ready", 64'(in_ready), 64'(1));
      chk("midrst_out_valid", 64'(out_valid), 64'(0));
      chk("midrst_sign", 64'(sign), 64'(0));
      chk("midrst_mag", 64'(mag), 64'(0));
      repeat (10) begin
         @(negedge clk);
         #1;
         chk("midrst_no_out", 64'(out_valid), 64'(0));
      end
      send(25'h1FFFF00, 0);

      // Reset wins over an offered word in IDLE
      rst      = 1'b1;
      in_valid = 1'b1;
      data_in  = 25'h0000123;
      @(negedge clk);
      #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      chk("rstprio_in_ready", 64'(in_ready), 64'(1));
      repeat (8) begin
         @(negedge clk);
         #1;
         chk("rstprio_no_out", 64'(out_valid), 64'(0));
      end

      // Random stream with random valid/ready
      fork
         begin
            int acc;
            acc = 0;
            while (acc < 10000) begin
               @(negedge clk);
               #1;
               in_valid = (($urandom % 8) != 0);
               data_in  = pick_word();
               if (in_valid && in_ready) begin
                  sb.push_back(model(data_in));
                  acc++;
               end
            end
            @(negedge clk);
            #1;
            in_valid    = 1'b0;
            stream_done = 1'b1;
         end
         begin
            while (!stream_done) begin
               @(negedge clk);
               #1;
               out_ready = (($urandom % 8) != 0);
            end
            out_ready = 1'b1;
         end
      join

      begin
         int b;
         b = 0;
         while (sb.size() != 0 && b < 200) begin
            @(negedge clk);
            b++;
         end
      end
      @(negedge clk);
      #3;
      chk("drain_empty", 64'(sb.size()), 64'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/twos_to_signmag25.md
TWOS_TO_SIGNMAG25 -- requirements
Module: twos_to_signmag25

Interface
REQ-001 SHALL provide parameter WIDTH, default 25, data width in bits.
REQ-002 SHALL provide parameter CHUNK, default 5, bits converted per cycle; WIDTH SHALL be an integer multiple of CHUNK.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  data_in is valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a word.
REQ-007 SHALL have port data_in  input  WIDTH  two's-complement operand, e.g. ADDSUB mantissa result.
REQ-008 SHALL have port out_valid  output  1  sign/mag/flags valid.
REQ-009 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-010 SHALL have port sign  output  1  data_in[WIDTH-1] of the accepted word.
REQ-011 SHALL have port mag  output  WIDTH  unsigned magnitude |data_in|.
REQ-012 SHALL have port zero  output  1  mag equals 0.
REQ-013 SHALL have port min_neg  output  1  input was -2^(WIDTH-1).

Function
REQ-014 SHALL implement FSM states IDLE, CONV, DONE.
REQ-015 IDLE: in_ready=1; on in_valid=1, capture data_in and sign, clear chunk counter, set carry=1, go to CONV.
REQ-016 CONV: in_ready=0; each cycle SHALL process chunk k (bits k*CHUNK..k*CHUNK+CHUNK-1), LSB chunk first.
REQ-017 Per chunk, sign=1: mag chunk = ~data chunk + carry, with carry-out registered for the next chunk; sign=0: mag chunk = data chunk unchanged.
REQ-018 After WIDTH/CHUNK chunks (5 by default), SHALL enter DONE; final carry-out discarded.
REQ-019 DONE: out_valid=1; sign, mag, zero, min_neg SHALL be held stable while out_valid=1 and out_ready=0.
REQ-020 DONE with out_ready=1: go to IDLE; no new word is accepted in the same cycle.
REQ-021 Latency: out_valid SHALL rise exactly WIDTH/CHUNK+1 cycles after the accept cycle (6 by default); throughput one word per WIDTH/CHUNK+2 cycles with out_ready held high.
REQ-022 in_valid SHALL be ignored outside IDLE; data_in changes outside IDLE SHALL have no effect.
REQ-023 min_neg SHALL be 1 only for data_in = 1 followed by WIDTH-1 zeros; mag SHALL then equal the same bit pattern, read as unsigned 2^(WIDTH-1).
REQ-024 zero and min_neg SHALL be valid only while out_valid=1 and SHALL be 0 otherwise.

Reset
REQ-025 rst=1 at a clock edge SHALL force IDLE, in_ready=1, out_valid=0, sign=0, mag=0, zero=0, min_neg=0, carry=0, counter=0.
REQ-026 Reset in CONV or DONE SHALL discard the word in flight; no out_valid SHALL follow.
REQ-027 rst SHALL take priority over every handshake in the same cycle.

Structure
REQ-028 Shared package ktsnc_pkg SHALL hold the default WIDTH (25), the default CHUNK (5) and the FSM state type.
REQ-029 Chunk arithmetic SHALL be one sub-module, twos_chunk: CHUNK-bit conditional invert plus carry-in, giving the sum and carry-out; combinational only.
REQ-030 Handshake, counter and result registers SHALL live in twos_to_signmag25.

Verification
REQ-031 data_in=25'h1FFFFFF (-1) -> sign=1, mag=25'h0000001, zero=0, min_neg=0, out_valid 6 cycles after accept.
REQ-032 data_in=25'h1000000 -> sign=1, mag=25'h1000000, min_neg=1, zero=0.
REQ-033 data_in=25'h0000000 -> sign=0, mag=0, zero=1; data_in=25'h0ABCDEF -> sign=0, mag=25'h0ABCDEF.
REQ-034 data_in=25'h1FFFFF6 (-10), out_ready low 3 cycles -> outputs held (sign=1, mag=25'h000000A), in_ready=0 throughout, single handshake on out_ready=1.
REQ-035 rst pulsed on the 3rd CONV cycle -> in_ready=1 next cycle, no out_valid; next word 25'h1FFFF00 -> mag=25'h0000100.
REQ-036 Random back-to-back stream (>=10k words, random in_valid/out_ready) -> every result matches a reference abs/sign model, in order, none dropped or duplicated.
